// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch: walks the PC and assembles 1/2-byte instructions
module ifetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [7:0]        im_data,
    input  logic              stall,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] target,
    output logic [7:0]        opcode_out,
    output logic [7:0]        operand_out,
    output logic              valid,
    output logic [ADDR_W-1:0] ret_addr
);

    typedef enum logic {S_OP, S_OD} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [7:0]        op_r, op_nx;
    logic [7:0]        od_r, od_nx;
    logic              valid_r, valid_nx;

    // Opcodes that carry an 8-bit operand in the following byte
    function automatic logic is_two_byte(input logic [7:0] b);
        logic alu_imm;
        alu_imm = b[3] && (b[7:4] >= 4'h8) && (b[7:4] <= 4'hE);
        return (b == 8'h03) || (b == 8'h05) ||
               (b[7:3] == 5'b00001) || (b[7:3] == 5'b00110) ||
               (b[7:3] == 5'b01011) || alu_imm;
    endfunction

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        op_nx    = op_r;
        od_nx    = od_r;
        valid_nx = valid_r;
        if (load_pc) begin
            // Redirect flushes any half-assembled instruction, even under stall
            pc_nx    = target;
            state_nx = S_OP;
            op_nx    = 8'h00;
            od_nx    = 8'h00;
            valid_nx = 1'b0;
        end else if (!stall) begin
            pc_nx = pc + ADDR_W'(1);
            case (state)
                S_OP: begin
                    op_nx = im_data;
                    if (is_two_byte(im_data)) begin
                        valid_nx = 1'b0;
                        state_nx = S_OD;
                    end else begin
                        od_nx    = 8'h00;
                        valid_nx = 1'b1;
                    end
                end
                S_OD: begin
                    od_nx    = im_data;
                    valid_nx = 1'b1;
                    state_nx = S_OP;
                end
                default: state_nx = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_OP;
            pc      <= RESET_PC;
            op_r    <= 8'h00;
            od_r    <= 8'h00;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            op_r    <= op_nx;
            od_r    <= od_nx;
            valid_r <= valid_nx;
        end
    end

    assign im_addr     = pc;
    assign ret_addr    = pc;
    assign valid       = valid_r;
    assign opcode_out  = valid_r ? op_r : 8'h00;
    assign operand_out = valid_r ? od_r : 8'h00;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - directed scoreboard bench for ifetch_stage
module tb_ifetch_stage;

    logic       clk = 1'b0;
    logic       rst, stall, load_pc;
    logic [7:0] target;
    logic [7:0] im_addr, im_data, opcode_out, operand_out, ret_addr;
    logic       valid;

    logic       rst2;
    logic [7:0] im_addr2, im_data2, opcode_out2, operand_out2, ret_addr2;
    logic       valid2;

    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] od;
        logic [7:0] ret;
    } issue_t;
    issue_t sbq[$];

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign im_data  = mem[im_addr];
    assign im_data2 = mem[im_addr2];

    ifetch_stage #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
        .stall(stall), .load_pc(load_pc), .target(target),
        .opcode_out(opcode_out), .operand_out(operand_out),
        .valid(valid), .ret_addr(ret_addr)
    );

    ifetch_stage #(.ADDR_W(8), .RESET_PC(8'hFF)) u_dut_wrap (
        .clk(clk), .rst(rst2), .im_addr(im_addr2), .im_data(im_data2),
        .stall(1'b0), .load_pc(1'b0), .target(8'h00),
        .opcode_out(opcode_out2), .operand_out(operand_out2),
        .valid(valid2), .ret_addr(ret_addr2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    // One clock; any fresh issue from the main DUT is matched against the scoreboard
    task automatic step();
        logic held;
        issue_t e;
        held = stall && !load_pc && !rst;
        @(posedge clk);
        #1;
        if (valid && !held) begin
            total++;
            assert (sbq.size() > 0) passes++;
            else $error("FAIL sb_unexpected_issue observed=%02h expected=none", opcode_out);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_opcode", opcode_out, e.op);
                check("sb_operand", operand_out, e.od);
                check("sb_ret_addr", ret_addr, e.ret);
            end
        end
    endtask

    function automatic issue_t mk(input logic [7:0] op, input logic [7:0] od, input logic [7:0] ret);
        issue_t r;
        r.op = op; r.od = od; r.ret = ret;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; load_pc = 1'b0; target = 8'h00;

        // Reset state, then two 1-byte instructions
        mem[8'h00] = 8'h01; mem[8'h01] = 8'h02;
        step();
        check("rst_valid", {7'd0, valid}, 8'h00);
        check("rst_opcode", opcode_out, 8'h00);
        check("rst_operand", operand_out, 8'h00);
        check("rst_ret_addr", ret_addr, 8'h00);
        sbq.push_back(mk(8'h01, 8'h00, 8'h01));
        sbq.push_back(mk(8'h02, 8'h00, 8'h02));
        rst = 1'b0;
        step();
        check("one_byte_valid", {7'd0, valid}, 8'h01);
        step();
        rst = 1'b1; step();

        // Two-byte MVI: bubble then full issue
        mem[8'h00] = 8'h5B; mem[8'h01] = 8'h7E;
        sbq.push_back(mk(8'h5B, 8'h7E, 8'h02));
        rst = 1'b0;
        step();
        check("two_byte_bubble_valid", {7'd0, valid}, 8'h00);
        check("two_byte_bubble_opcode", opcode_out, 8'h00);
        step();
        check("two_byte_valid", {7'd0, valid}, 8'h01);
        rst = 1'b1; step();

        // Stall holds a valid ADI for three cycles
        mem[8'h00] = 8'h88; mem[8'h01] = 8'h05; mem[8'h02] = 8'h01;
        sbq.push_back(mk(8'h88, 8'h05, 8'h02));
        rst = 1'b0;
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {7'd0, valid}, 8'h01);
            check("stall_opcode", opcode_out, 8'h88);
            check("stall_operand", operand_out, 8'h05);
            check("stall_pc", ret_addr, 8'h02);
        end
        stall = 1'b0;
        sbq.push_back(mk(8'h01, 8'h00, 8'h03));
        step();
        check("post_stall_valid", {7'd0, valid}, 8'h01);
        rst = 1'b1; step();

        // Redirect in S_OD with simultaneous stall
        mem[8'h00] = 8'h03; mem[8'h01] = 8'h99;
        mem[8'h40] = 8'h0A; mem[8'h41] = 8'h10;
        rst = 1'b0;
        step();
        load_pc = 1'b1; target = 8'h40; stall = 1'b1;
        step();
        check("redirect_valid", {7'd0, valid}, 8'h00);
        check("redirect_opcode", opcode_out, 8'h00);
        check("redirect_pc", ret_addr, 8'h40);
        load_pc = 1'b0; stall = 1'b0;
        sbq.push_back(mk(8'h0A, 8'h10, 8'h42));
        step(); step();
        rst = 1'b1; step();

        // Reset in S_OD discards the partial instruction
        mem[8'h00] = 8'h5B; mem[8'h01] = 8'h7E;
        rst = 1'b0;
        step();
        rst = 1'b1; load_pc = 1'b1; target = 8'h80;
        step();
        check("rst_sod_pc", ret_addr, 8'h00);
        check("rst_sod_valid", {7'd0, valid}, 8'h00);
        check("rst_sod_opcode", opcode_out, 8'h00);
        rst = 1'b0; load_pc = 1'b0;
        sbq.push_back(mk(8'h5B, 8'h7E, 8'h02));
        step(); step();
        rst = 1'b1; step();

        // Decode sweep across 1- and 2-byte classes
        mem[8'h00] = 8'hF8; mem[8'h01] = 8'h30; mem[8'h02] = 8'h11;
        mem[8'h03] = 8'hE8; mem[8'h04] = 8'h22; mem[8'h05] = 8'h18;
        mem[8'h06] = 8'h05; mem[8'h07] = 8'h33;
        sbq.push_back(mk(8'hF8, 8'h00, 8'h01));
        sbq.push_back(mk(8'h30, 8'h11, 8'h03));
        sbq.push_back(mk(8'hE8, 8'h22, 8'h05));
        sbq.push_back(mk(8'h18, 8'h00, 8'h06));
        sbq.push_back(mk(8'h05, 8'h33, 8'h08));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1; step();
        check("sb_drained", 8'(sbq.size()), 8'h00);

        // PC wrap from RESET_PC=FF, operand fetched from 00
        mem[8'hFF] = 8'hC9; mem[8'h00] = 8'hF0;
        check("wrap_rst_pc", ret_addr2, 8'hFF);
        rst2 = 1'b0;
        step();
        check("wrap_bubble_valid", {7'd0, valid2}, 8'h00);
        step();
        check("wrap_valid", {7'd0, valid2}, 8'h01);
        check("wrap_opcode", opcode_out2, 8'hC9);
        check("wrap_operand", operand_out2, 8'hF0);
        check("wrap_ret_addr", ret_addr2, 8'h01);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage directly upstream of the CCG1/CCG2 control pipeline.
- Walks the program counter over byte-wide instruction memory and assembles 1- or 2-byte instructions (opcode plus optional 8-bit operand `od`).
- Presents the opcode to CCG1's opcode_in, with a NOP bubble whenever no instruction is ready.
- Accepts PC redirects (jump/call/return) and a stall from downstream; supplies the return address for call pushes.

Parameters:
- ADDR_W, 8: program counter / instruction-memory address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- im_addr  output  ADDR_W  instruction memory address; combinational copy of the PC register.
- im_data  input  8  instruction memory read data; combinational read, valid in the same cycle as im_addr.
- stall  input  1  downstream hold; freezes all state.
- load_pc  input  1  PC redirect request (L_PC from control).
- target  input  ADDR_W  redirect destination.
- opcode_out  output  8  issued opcode; 8'h00 (NOP) whenever valid=0.
- operand_out  output  8  operand byte of the issued instruction; 8'h00 for 1-byte instructions.
- valid  output  1  high for exactly one unstalled cycle per completed instruction.
- ret_addr  output  ADDR_W  address of the byte following the issued instruction (current PC).

Behaviour:
- Registers: pc, state {S_OP, S_OD}, op_r, od_r, valid_r.
- opcode_out = valid_r ? op_r : 8'h00.
- operand_out = valid_r ? od_r : 8'h00.
- ret_addr = pc.
- Reset (rst=1 at a clock edge): pc=RESET_PC, state=S_OP, op_r=00, od_r=00, valid=0. Outputs are therefore 00/00/0, ret_addr=RESET_PC.
- Priority per edge: rst > load_pc > stall > normal fetch.
- Two-byte decode (applied to im_data in S_OP): 0000_0011 JUD, 0000_0101 CUD, 0000_1xxx JCD, 0011_0xxx CCD, 0101_1xxx MVI, and ccc_1xxx with ccc in 1000..1110 (ADI, SBI, ACI, SCI, ANI, ORI, XRI).
- All other encodings are 1-byte, including 1111_xxxx.
- S_OP, no stall:
  - op_r<=im_data; pc<=pc+1.
  - If two-byte: valid<=0, od_r unchanged, state<=S_OD.
  - Else: od_r<=00, valid<=1, stay in S_OP.
- S_OD, no stall: od_r<=im_data; pc<=pc+1; valid<=1; state<=S_OP.
- Latency: a 1-byte instruction is valid one edge after its fetch cycle. A 2-byte instruction is valid one edge after the operand-fetch cycle (2 cycles total).
- Stall=1: pc, state, op_r, od_r, valid_r all hold. A valid instruction stays presented unchanged until stall drops.
- load_pc=1 (any state, overrides stall): pc<=target, state<=S_OP, valid<=0, op_r<=00, od_r<=00. This flushes any partially assembled instruction; the first post-redirect opcode is fetched from target in the next cycle.
- PC wraps modulo 2^ADDR_W: FF+1=00, including mid-instruction (opcode at FF, operand fetched from 00).
- Simultaneous rst and load_pc: reset wins.
- Reset mid 2-byte fetch discards the partial instruction.

Test Plan:
- Reset then memory {00:01 CLR, 01:02 CLC}: cycle 1 opcode_out=01, valid=1, ret_addr=01; cycle 2 opcode_out=02, ret_addr=02; operand_out=00 both cycles.
- Two-byte {00:5B MVI r3, 01:7E}: after edge 1 valid=0, opcode_out=00; after edge 2 valid=1, opcode_out=5B, operand_out=7E, ret_addr=02.
- Stall asserted while 88/05 (ADI) is valid for 3 cycles: outputs stay 88/05, valid=1, pc=02 throughout; next instruction issues one cycle after stall drops.
- load_pc=1, target=40 in S_OD after opcode 03 fetched (with stall=1 the same cycle): valid=0, pc=40 next edge; mem[40]=0A (JCD) then mem[41]=10 -> issues 0A/10, ret_addr=42.
- PC wrap: RESET_PC=FF, mem[FF]=C9 (ANI), mem[00]=F0: issues C9/F0, ret_addr=01.
- rst asserted in S_OD: next edge pc=RESET_PC, valid=0, opcode_out=00; fetch restarts cleanly from RESET_PC.
